// File: rtl/alu_multicycle_pkg.sv
// Shared opcode constants and FSM state encoding for the execute-stage ALU.
// The ALU-control decoder imports the same opcode constants.
package alu_multicycle_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOVE = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/alu_multicycle_muldiv.sv
// Iterative one-bit-per-step datapath: shift-add multiply (mode=0) and
// restoring divide (mode=1). Sequencing is owned by the caller.
module alu_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // hi: partial product / partial remainder; lo: multiplier / dividend->quotient
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, m_q};
        if (load) begin
            hi_d = '0;
            m_d  = mode ? b_in : a_in;
            lo_d = mode ? a_in : b_in;
        end else if (step) begin
            if (!mode) begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end else if (!diff[WIDTH+1]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            m_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            m_q  <= m_d;
        end
    end

    assign product_hi = hi_q;
    assign product_lo = lo_q;
    assign quotient   = lo_q;
    assign remainder  = hi_q;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with start/busy/done handshake. Single-cycle ops finish
// one cycle after start; mult/div iterate WIDTH cycles in alu_iter_muldiv.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic             done_q, done_d, zero_q, zero_d, dbz_q, dbz_d;

    logic             accept, iter_start, md_mode;
    logic [WIDTH-1:0] fin_lo, fin_hi;
    logic             fin_dbz;
    logic [WIDTH-1:0] prod_hi, prod_lo, quo, rem;

    assign accept     = start && (state_q == S_IDLE);
    // divide by zero never enters the iterative path
    assign iter_start = accept && ((operation == OP_MULT) ||
                                   ((operation == OP_DIV) && (b != '0)));
    assign md_mode    = accept ? (operation == OP_DIV) : (op_q == OP_DIV);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .reset      (reset),
        .mode       (md_mode),
        .load       (iter_start),
        .step       (state_q == S_ITER),
        .a_in       (a),
        .b_in       (b),
        .product_hi (prod_hi),
        .product_lo (prod_lo),
        .quotient   (quo),
        .remainder  (rem)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = iter_start ? S_ITER : S_FINISH;
            S_ITER:   if (cnt_q == CW'(1)) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_comb begin
        fin_lo  = a_q + b_q;
        fin_hi  = '0;
        fin_dbz = 1'b0;
        case (op_q)
            OP_NOP:  fin_lo = '0;
            OP_SUB,
            OP_CMP:  fin_lo = a_q - b_q;
            OP_MULT: begin fin_lo = prod_lo; fin_hi = prod_hi; end
            OP_DIV: begin
                if (b_q == '0) begin
                    fin_lo  = '1;
                    fin_hi  = a_q;
                    fin_dbz = 1'b1;
                end else begin
                    fin_lo = quo;
                    fin_hi = rem;
                end
            end
            OP_MOVE: fin_lo = b_q;
            OP_SWAP: begin fin_lo = b_q; fin_hi = a_q; end
            OP_AND:  fin_lo = a_q & b_q;
            OP_OR:   fin_lo = a_q | b_q;
            default: fin_lo = a_q + b_q;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        if (accept) begin
            op_d = operation;
            a_d  = a;
            b_d  = b;
        end
        if (iter_start)              cnt_d = CW'(WIDTH);
        else if (state_q == S_ITER)  cnt_d = cnt_q - CW'(1);
        if (state_q == S_FINISH) begin
            res_d    = fin_lo;
            res_hi_d = fin_hi;
            zero_d   = (fin_lo == '0);
            dbz_d    = fin_dbz;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign done        = done_q;
    assign result      = res_q;
    assign result_hi   = res_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle (WIDTH=16), hand-computed expectations.
module tb_alu_multicycle;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   operation = 4'b0000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, div_by_zero;
    logic [W-1:0] result, result_hi;

    int n_chk = 0;
    int n_err = 0;
    int dbl_done = 0;
    int extra_done = 0;
    logic done_prev = 1'b0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .operation   (operation),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // done must never be high on two consecutive cycles
    always @(negedge clk) begin
        if (done && done_prev) dbl_done++;
        done_prev = done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives start for one cycle; returns #1 after the accepting edge (edge 0).
    task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        start = 1'b1; operation = op; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; operation = 4'b1111; a = 16'hDEAD; b = 16'hBEEF;
    endtask

    // Counts edges after edge 0 until done; -1 if the budget expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_result_hi", result_hi, 0);
        chk("rst_zero", zero, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset = 1'b0;

        // add, busy exactly one cycle
        issue(4'b0001, 16'h1234, 16'h0001);
        chk("add_busy_e0", busy, 1);
        chk("add_done_e0", done, 0);
        @(posedge clk); #1;
        chk("add_done_e1", done, 1);
        chk("add_busy_e1", busy, 0);
        chk("add_result", result, 16'h1235);
        chk("add_zero", zero, 0);
        @(posedge clk); #1;
        chk("add_done_e2", done, 0);

        issue(4'b0010, 16'd5, 16'd7);
        wait_done(lat);
        chk("sub_lat", lat, 1);
        chk("sub_result", result, 16'hFFFE);
        chk("sub_result_hi", result_hi, 0);

        issue(4'b1001, 16'd9, 16'd9);
        wait_done(lat);
        chk("cmp_result", result, 0);
        chk("cmp_zero", zero, 1);

        issue(4'b0110, 16'hAAAA, 16'h5555);
        wait_done(lat);
        chk("swap_result", result, 16'h5555);
        chk("swap_result_hi", result_hi, 16'hAAAA);
        chk("swap_zero", zero, 0);

        // mult with an ignored start at edge 5
        issue(4'b0011, 16'd300, 16'd500);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin start = 1'b1; operation = 4'b0001; a = 16'd1; b = 16'd1; end
            if (i == 5) begin
                start = 1'b0;
                chk("mult_busy_e5", busy, 1);
                chk("mult_hold_result", result, 16'h5555);
            end
            if (done) begin lat = i; break; end
        end
        chk("mult_lat", lat, W + 1);
        chk("mult_result", result, 16'h49F0);
        chk("mult_result_hi", result_hi, 16'h0002);
        extra_done = 0;
        repeat (4) begin @(posedge clk); #1; if (done) extra_done++; end
        chk("mult_no_restart", extra_done, 0);
        chk("mult_idle", busy, 0);

        issue(4'b0100, 16'd1000, 16'd7);
        wait_done(lat);
        chk("div_lat", lat, W + 1);
        chk("div_quot", result, 16'd142);
        chk("div_rem", result_hi, 16'd6);
        chk("div_dbz", div_by_zero, 0);

        issue(4'b0100, 16'h00FF, 16'h0000);
        wait_done(lat);
        chk("div0_lat", lat, 1);
        chk("div0_result", result, 16'hFFFF);
        chk("div0_result_hi", result_hi, 16'h00FF);
        chk("div0_dbz", div_by_zero, 1);

        issue(4'b0001, 16'd2, 16'd3);
        wait_done(lat);
        chk("add_after_div0", result, 16'd5);
        chk("dbz_cleared", div_by_zero, 0);

        // reset aborts a mult at edge 6
        issue(4'b0011, 16'd300, 16'd500);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_result_hi", result_hi, 0);
        extra_done = 0;
        repeat (20) begin @(posedge clk); #1; if (done) extra_done++; end
        chk("abort_no_done", extra_done, 0);

        issue(4'b0001, 16'h0FFF, 16'h0001);
        wait_done(lat);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_result", result, 16'h1000);

        // back-to-back: second start in the cycle right after done
        issue(4'b1000, 16'hF000, 16'h000F);
        wait_done(lat);
        chk("b2b_first", result, 16'hF00F);
        start = 1'b1; operation = 4'b0111; a = 16'hFF00; b = 16'h0FF0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accept_busy", busy, 1);
        chk("b2b_done_gap", done, 0);
        @(posedge clk); #1;
        chk("b2b_done", done, 1);
        chk("b2b_result", result, 16'h0F00);

        repeat (2) @(posedge clk);
        chk("no_double_done", dbl_done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
